program_scheduler: RTL

//   Round-robin time-slice scheduler that sequences program_counter between resident programs.

---
 rtl/sched_pkg.sv | 29 ++
 rtl/rr_picker.sv | 37 +++
 rtl/program_scheduler.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sched_pkg.sv
// ============================================================================
// Module      : sched_pkg
// Description : Shared types and default sizes for the program scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sched_pkg;

  localparam int DEF_N_PROGS = 8;
  localparam int DEF_PID_W   = 3;
  localparam int DEF_ADDR_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SAVE = 2'd2,
    ST_LOAD = 2'd3
  } sched_state_t;

  // Context table entry; pc field is sized for the widest supported PC.
  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] pc;
  } ctx_entry_t;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Rotated priority encoder returning the first set mask bit
//               at or after start, wrapping modulo N_PROGS.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter int N_PROGS = 8,
  parameter int PID_W   = 3
) (
  input  logic [N_PROGS-1:0] mask,
  input  logic [PID_W-1:0]   start,
  output logic               found,
  output logic [PID_W-1:0]   next_id
);

  logic [PID_W-1:0] w_idx;

  // Scan from the far end so the nearest hit is the last one written.
  always_comb begin
    found   = 1'b0;
    next_id = start;
    w_idx   = start;
    for (int i = N_PROGS - 1; i >= 0; i--) begin
      w_idx = start + PID_W'(i);
      if (mask[w_idx]) begin
        found   = 1'b1;
        next_id = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/program_scheduler.sv
// ============================================================================
// Module      : program_scheduler
// Description : Round-robin time-slice scheduler driving PC loads between
//               resident program slots. Optional SCHED_STATS_EN adds a
//               switch_count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_scheduler
  import sched_pkg::*;
#(
  parameter int N_PROGS = DEF_N_PROGS,
  parameter int PID_W   = DEF_PID_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       quantum_in,
  input  logic              quantum_we,
  input  logic              prog_create,
  input  logic [PID_W-1:0]  prog_id_in,
  input  logic [ADDR_W-1:0] prog_start_pc,
  input  logic              prog_end,
  input  logic              yield,
  input  logic              stop,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic [PID_W-1:0]  run_id,
  output logic              run_valid,
  output logic              load_pc,
  output logic [ADDR_W-1:0] load_addr,
  output logic              busy,
  output logic              idle,
  output logic              create_err
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]       switch_count
`endif
);

  sched_state_t       r_state;
  ctx_entry_t         r_ctx      [N_PROGS];
  ctx_entry_t         w_ctx_next [N_PROGS];
  logic [31:0]        r_quantum;
  logic [31:0]        r_count;
  logic               r_end;

  logic [N_PROGS-1:0] w_run_onehot;
  logic [N_PROGS-1:0] w_valid_cur;
  logic [N_PROGS-1:0] w_valid_freed;
  logic [N_PROGS-1:0] w_valid_next;
  logic [N_PROGS-1:0] w_mask;
  logic               w_free;
  logic               w_create_ok;
  logic               w_create_err;
  logic               w_other_valid;
  logic               w_expire;
  logic               w_found;
  logic [PID_W-1:0]   w_start;
  logic [PID_W-1:0]   w_pick;

  always_comb begin
    w_run_onehot         = '0;
    w_run_onehot[run_id] = 1'b1;
    w_free               = (r_state == ST_SAVE) && r_end;
    for (int k = 0; k < N_PROGS; k++) begin
      w_valid_cur[k] = r_ctx[k].valid;
    end
    // An ending slot is freed before any same-cycle create is judged.
    w_valid_freed = w_valid_cur & ~(w_free ? w_run_onehot : '0);
    w_create_err  = prog_create && w_valid_freed[prog_id_in];
    w_create_ok   = prog_create && !w_valid_freed[prog_id_in];

    for (int k = 0; k < N_PROGS; k++) begin
      w_ctx_next[k]       = r_ctx[k];
      w_ctx_next[k].valid = w_valid_freed[k];
    end
    if ((r_state == ST_SAVE) && !r_end) begin
      w_ctx_next[run_id].pc = DEF_ADDR_W'(pc_cur + ADDR_W'(1));
    end
    if (w_create_ok) begin
      w_ctx_next[prog_id_in].valid = 1'b1;
      w_ctx_next[prog_id_in].pc    = DEF_ADDR_W'(prog_start_pc);
    end
    for (int k = 0; k < N_PROGS; k++) begin
      w_valid_next[k] = w_ctx_next[k].valid;
    end

    // IDLE may start a slot created this cycle; SAVE only sees resident slots.
    w_mask        = (r_state == ST_IDLE) ? w_valid_next : w_valid_freed;
    w_start       = run_id + PID_W'(1);
    w_other_valid = |(w_valid_cur & ~w_run_onehot);
    w_expire      = (r_quantum != 32'd0) && (r_count >= (r_quantum - 32'd1));
  end

  rr_picker #(
    .N_PROGS (N_PROGS),
    .PID_W   (PID_W)
  ) u_picker (
    .mask    (w_mask),
    .start   (w_start),
    .found   (w_found),
    .next_id (w_pick)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      for (int k = 0; k < N_PROGS; k++) begin
        r_ctx[k] <= '0;
      end
      r_quantum  <= '0;
      r_count    <= '0;
      r_end      <= 1'b0;
      run_id     <= '0;
      run_valid  <= 1'b0;
      load_pc    <= 1'b0;
      load_addr  <= '0;
      busy       <= 1'b0;
      idle       <= 1'b1;
      create_err <= 1'b0;
`ifdef SCHED_STATS_EN
      switch_count <= '0;
`endif
    end else begin
      for (int k = 0; k < N_PROGS; k++) begin
        r_ctx[k] <= w_ctx_next[k];
      end
      if (quantum_we) begin
        r_quantum <= quantum_in;
      end
      create_err <= w_create_err;
      idle       <= ~|w_valid_next;
      load_pc    <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state   <= ST_LOAD;
            run_id    <= w_pick;
            load_pc   <= 1'b1;
            load_addr <= ADDR_W'(w_ctx_next[w_pick].pc);
            busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!stop) begin
            if (r_count != 32'hFFFF_FFFF) begin
              r_count <= r_count + 32'd1;
            end
            if (prog_end || yield) begin
              r_state   <= ST_SAVE;
              r_end     <= prog_end;
              busy      <= 1'b1;
              run_valid <= 1'b0;
            end else if (w_expire) begin
              if (w_other_valid) begin
                r_state   <= ST_SAVE;
                r_end     <= 1'b0;
                busy      <= 1'b1;
                run_valid <= 1'b0;
              end else begin
                r_count <= '0;
              end
            end
          end
        end
        ST_SAVE: begin
          if (w_found) begin
            r_state   <= ST_LOAD;
            run_id    <= w_pick;
            load_pc   <= 1'b1;
            load_addr <= ADDR_W'(w_ctx_next[w_pick].pc);
`ifdef SCHED_STATS_EN
            switch_count <= switch_count + 32'd1;
`endif
          end else begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_state   <= ST_RUN;
          r_count   <= '0;
          busy      <= 1'b0;
          run_valid <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
